// File: rtl/lsu_hazard_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_hazard_stage_if
//   Bundles every signal of the load/store stage except clock and reset.
//   Signal names keep their direction prefix as seen from the stage itself.
//
//   EXU side : i_valid, o_ready, i_rd, i_wen, i_load, i_store, i_funct3,
//              i_addr, i_wdata
//   Memory   : o_mem_req, i_mem_gnt, o_mem_we, o_mem_addr, o_mem_wdata,
//              o_mem_wmask, i_mem_rvalid, i_mem_rdata
//   WBU side : o_valid, i_wb_ready, o_rd, o_wen, o_data, o_fault
//   Hazard   : o_lsu_rd, o_lsu_wen, o_lsu_load, o_lsu_valid, o_lsu_ready,
//              o_lsu_data
//
//   slave  : the stage (drives o_*)
//   master : the surroundings (drive i_*)
// ---------------------------------------------------------------------------
interface lsu_hazard_stage_if;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_rd;
    logic        i_wen;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;

    logic        o_mem_req;
    logic        i_mem_gnt;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    logic        o_valid;
    logic        i_wb_ready;
    logic [4:0]  o_rd;
    logic        o_wen;
    logic [31:0] o_data;
    logic        o_fault;

    logic [4:0]  o_lsu_rd;
    logic        o_lsu_wen;
    logic        o_lsu_load;
    logic        o_lsu_valid;
    logic        o_lsu_ready;
    logic [31:0] o_lsu_data;

    modport slave (
        input  i_valid, i_rd, i_wen, i_load, i_store, i_funct3, i_addr, i_wdata,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_wb_ready,
        output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        output o_valid, o_rd, o_wen, o_data, o_fault,
        output o_lsu_rd, o_lsu_wen, o_lsu_load, o_lsu_valid, o_lsu_ready, o_lsu_data
    );

    modport master (
        output i_valid, i_rd, i_wen, i_load, i_store, i_funct3, i_addr, i_wdata,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_wb_ready,
        input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
        input  o_valid, o_rd, o_wen, o_data, o_fault,
        input  o_lsu_rd, o_lsu_wen, o_lsu_load, o_lsu_valid, o_lsu_ready, o_lsu_data
    );
endinterface

// File: rtl/lsu_hazard_stage.sv
// ---------------------------------------------------------------------------
// lsu_hazard_stage
//   Load/store stage between EXU and WBU. Takes one instruction at a time,
//   performs at most one memory access on a req/gnt/rvalid bus, holds the
//   result until WBU takes it, and publishes the hazard view used by the
//   decode-stage forward/stall unit.
//
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst_n : asynchronous active-low reset
//     bus     : lsu_hazard_stage_if.slave (EXU, memory, WBU, hazard signals)
//
//   Parameters:
//     TIMEOUT : WAIT cycles tolerated after grant before forcing a fault
//     CNT_W   : timeout counter width, 2**CNT_W > TIMEOUT
// ---------------------------------------------------------------------------
module lsu_hazard_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    lsu_hazard_stage_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t             state_q;
    state_t             state_d;

    logic [4:0]         rd_p1;
    logic               wen_p1;
    logic               load_p1;
    logic               store_p1;
    logic [2:0]         funct3_p1;
    logic [31:0]        data_p1;
    logic [31:0]        wdata_p1;
    logic               fault_p1;
    logic [CNT_W-1:0]   cnt_p1;

    logic               ready;
    logic               accept;
    logic               mem_op;
    logic               timeout;

    // Load result: pick the addressed lane, then sign/zero extend.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'h0, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'h0, h};
            default: load_extract = rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3,
                                              input logic [1:0] a);
        case (f3)
            3'b000:  store_mask = 4'b0001 << a;
            3'b001:  store_mask = a[1] ? 4'b1100 : 4'b0011;
            default: store_mask = 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across lanes so the mask alone selects.
    function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                               input logic [31:0] wd);
        case (f3)
            3'b000:  store_data = {4{wd[7:0]}};
            3'b001:  store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    // Draining DONE and accepting the next instruction can share a cycle.
    assign ready   = (state_q == IDLE) || ((state_q == DONE) && bus.i_wb_ready);
    assign accept  = bus.i_valid && ready;
    assign mem_op  = bus.i_load || bus.i_store;
    assign timeout = (cnt_p1 == CNT_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = mem_op ? REQ : DONE;
            end
            REQ: begin
                if (bus.i_mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (bus.i_mem_rvalid || timeout) state_d = DONE;
            end
            DONE: begin
                if (accept)               state_d = mem_op ? REQ : DONE;
                else if (bus.i_wb_ready)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- p0 -> p1: instruction latch, memory completion, result hold ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rd_p1     <= '0;
            wen_p1    <= 1'b0;
            load_p1   <= 1'b0;
            store_p1  <= 1'b0;
            funct3_p1 <= '0;
            data_p1   <= '0;
            wdata_p1  <= '0;
            fault_p1  <= 1'b0;
            cnt_p1    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_p1     <= bus.i_rd;
                wen_p1    <= bus.i_wen;
                load_p1   <= bus.i_load;
                // A load that also claims to be a store is issued as a load.
                store_p1  <= bus.i_store && !bus.i_load;
                funct3_p1 <= bus.i_funct3;
                data_p1   <= bus.i_addr;
                wdata_p1  <= bus.i_wdata;
                fault_p1  <= 1'b0;
            end else begin
                case (state_q)
                    REQ: begin
                        if (bus.i_mem_gnt) cnt_p1 <= '0;
                    end
                    WAIT: begin
                        // rvalid is checked first so it wins a tie with the timeout.
                        if (bus.i_mem_rvalid) begin
                            if (load_p1)
                                data_p1 <= load_extract(funct3_p1, data_p1[1:0], bus.i_mem_rdata);
                            fault_p1 <= 1'b0;
                        end else if (timeout) begin
                            fault_p1 <= 1'b1;
                            data_p1  <= '0;
                        end else begin
                            cnt_p1 <= cnt_p1 + CNT_W'(1);
                        end
                    end
                    DONE: begin
                        if (bus.i_wb_ready) fault_p1 <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // data_p1 still holds the full address while the access is outstanding.
    assign bus.o_ready     = ready;
    assign bus.o_mem_req   = (state_q == REQ);
    assign bus.o_mem_we    = store_p1;
    assign bus.o_mem_addr  = {data_p1[31:2], 2'b00};
    assign bus.o_mem_wdata = store_data(funct3_p1, wdata_p1);
    assign bus.o_mem_wmask = store_mask(funct3_p1, data_p1[1:0]);

    assign bus.o_valid     = (state_q == DONE);
    assign bus.o_rd        = rd_p1;
    assign bus.o_wen       = wen_p1;
    assign bus.o_data      = data_p1;
    assign bus.o_fault     = fault_p1;

    assign bus.o_lsu_rd    = rd_p1;
    assign bus.o_lsu_wen   = wen_p1;
    assign bus.o_lsu_load  = load_p1;
    assign bus.o_lsu_valid = (state_q == DONE);
    assign bus.o_lsu_ready = !((state_q == REQ) || (state_q == WAIT));
    assign bus.o_lsu_data  = data_p1;

endmodule

// File: tb/tb_lsu_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_hazard_stage
//   Directed bench for lsu_hazard_stage with a transaction-level reference
//   model (busy / granted / done flags plus arithmetic lane functions) and a
//   per-cycle comparator, alongside hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_lsu_hazard_stage;
    localparam int TIMEOUT = 255;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_hazard_stage_if bus();

    lsu_hazard_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
        int sz;
        int base;
        logic [31:0] sh;
        logic signed [31:0] s;
        sz   = acc_size(f3);
        base = (int'(a[1:0]) / sz) * sz;
        sh   = rdata >> (8 * base);
        if (sz == 1) begin
            s = $signed({sh[7:0], 24'h0}) >>> 24;
            return (f3 == 3'b000) ? s : (sh & 32'hFF);
        end
        if (sz == 2) begin
            s = $signed({sh[15:0], 16'h0}) >>> 16;
            return (f3 == 3'b001) ? s : (sh & 32'hFFFF);
        end
        return rdata;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int base;
        logic [3:0] m;
        sz   = acc_size(f3);
        base = (int'(a[1:0]) / sz) * sz;
        for (int i = 0; i < 4; i++) m[i] = (i >= base) && (i < base + sz);
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        logic [31:0] r;
        sz = acc_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    logic        m_busy = 0, m_gnt = 0, m_done = 0;
    int          m_wait = 0;
    logic [4:0]  m_rd = 0;
    logic        m_wen = 0, m_load = 0, m_store = 0, m_fault = 0;
    logic [2:0]  m_f3 = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_data = 0;

    always @(posedge clk or negedge rst_n) begin
        logic acc;
        if (!rst_n) begin
            m_busy = 0; m_gnt = 0; m_done = 0; m_wait = 0;
            m_rd = 0; m_wen = 0; m_load = 0; m_store = 0; m_fault = 0;
            m_f3 = 0; m_addr = 0; m_wdata = 0; m_data = 0;
        end else begin
            acc = bus.i_valid && !m_busy && (!m_done || bus.i_wb_ready);
            if (m_done && bus.i_wb_ready) begin
                m_done  = 0;
                m_fault = 0;
            end
            if (m_busy) begin
                if (!m_gnt) begin
                    if (bus.i_mem_gnt) begin m_gnt = 1; m_wait = 0; end
                end else if (bus.i_mem_rvalid) begin
                    m_busy = 0; m_done = 1;
                    if (m_load) m_data = exp_load(m_f3, m_addr, bus.i_mem_rdata);
                end else if (m_wait == TIMEOUT) begin
                    m_busy = 0; m_done = 1; m_fault = 1; m_data = 0;
                end else begin
                    m_wait++;
                end
            end
            if (acc) begin
                m_rd = bus.i_rd; m_wen = bus.i_wen; m_load = bus.i_load;
                m_store = bus.i_store && !bus.i_load; m_f3 = bus.i_funct3;
                m_addr = bus.i_addr; m_wdata = bus.i_wdata; m_data = bus.i_addr;
                m_fault = 0;
                if (bus.i_load || bus.i_store) begin m_busy = 1; m_gnt = 0; end
                else m_done = 1;
            end
        end
    end

    // ---------------- per-cycle comparator ----------------
    always @(negedge clk) begin
        logic exp_ready;
        exp_ready = !m_busy && (!m_done || bus.i_wb_ready);
        chk("ready",     32'(bus.o_ready),     32'(exp_ready));
        chk("valid",     32'(bus.o_valid),     32'(m_done));
        chk("lsu_valid", 32'(bus.o_lsu_valid), 32'(m_done));
        chk("lsu_ready", 32'(bus.o_lsu_ready), 32'(!m_busy));
        chk("mem_req",   32'(bus.o_mem_req),   32'(m_busy && !m_gnt));
        if (m_done) begin
            chk("data",     bus.o_data,            m_data);
            chk("lsu_data", bus.o_lsu_data,        m_data);
            chk("rd",       32'(bus.o_rd),         32'(m_rd));
            chk("lsu_rd",   32'(bus.o_lsu_rd),     32'(m_rd));
            chk("wen",      32'(bus.o_wen),        32'(m_wen));
            chk("lsu_wen",  32'(bus.o_lsu_wen),    32'(m_wen));
            chk("fault",    32'(bus.o_fault),      32'(m_fault));
            chk("lsu_load", 32'(bus.o_lsu_load),   32'(m_load));
        end
        if (m_busy && !m_gnt) begin
            chk("mem_addr", bus.o_mem_addr, m_addr & 32'hFFFF_FFFC);
            chk("mem_we",   32'(bus.o_mem_we), 32'(m_store));
            if (m_store) begin
                chk("mem_wmask", 32'(bus.o_mem_wmask), 32'(exp_mask(m_f3, m_addr)));
                chk("mem_wdata", bus.o_mem_wdata, exp_wdata(m_f3, m_wdata));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic wen);
        bus.i_load = ld; bus.i_store = st; bus.i_funct3 = f3;
        bus.i_addr = addr; bus.i_wdata = wd; bus.i_rd = rd; bus.i_wen = wen;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic wen);
        set_in(ld, st, f3, addr, wd, rd, wen);
        bus.i_valid = 1;
        step();
        bus.i_valid = 0;
    endtask

    // rv_dly > TIMEOUT means no rvalid at all.
    task automatic finish_mem(input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        for (int k = 0; k < gnt_dly; k++) begin
            chk("req_lsu_ready", 32'(bus.o_lsu_ready), 0);
            step();
        end
        bus.i_mem_gnt = 1;
        step();
        bus.i_mem_gnt = 0;
        for (int k = 0; k < rv_dly && k <= TIMEOUT; k++) begin
            chk("wait_lsu_ready", 32'(bus.o_lsu_ready), 0);
            step();
        end
        if (rv_dly <= TIMEOUT) begin
            bus.i_mem_rvalid = 1;
            bus.i_mem_rdata  = rdata;
            step();
            bus.i_mem_rvalid = 0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (!bus.o_valid && k < 600) begin
            step();
            k++;
        end
        chk("drain_valid", 32'(bus.o_valid), 1);
        bus.i_wb_ready = 1;
        step();
        bus.i_wb_ready = 0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  mask;
        logic [31:0] lanes;
    } st_vec_t;

    ld_vec_t lv[6] = '{
        '{3'b100, 32'h0000_0101, 32'h1234_8056, 32'h0000_0080},
        '{3'b001, 32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001},
        '{3'b101, 32'h0000_0103, 32'h8001_0000, 32'h0000_8001},
        '{3'b000, 32'h0000_0100, 32'h0000_007F, 32'h0000_007F},
        '{3'b011, 32'h0000_0105, 32'h89AB_CDEF, 32'h89AB_CDEF},
        '{3'b010, 32'h0000_0106, 32'h0BAD_F00D, 32'h0BAD_F00D}
    };

    st_vec_t sv[4] = '{
        '{3'b000, 32'h0000_0201, 32'h1122_3377, 4'b0010, 32'h7777_7777},
        '{3'b000, 32'h0000_0203, 32'h1122_33A5, 4'b1000, 32'hA5A5_A5A5},
        '{3'b001, 32'h0000_0205, 32'h5555_BEEF, 4'b0011, 32'hBEEF_BEEF},
        '{3'b010, 32'h0000_0207, 32'h0102_0304, 4'b1111, 32'h0102_0304}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid = 0; bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = 0;
        bus.i_wb_ready = 0;
        set_in(0, 0, 3'b000, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",     32'(bus.o_ready), 1);
        chk("rst_mem_req",   32'(bus.o_mem_req), 0);
        chk("rst_valid",     32'(bus.o_valid), 0);
        chk("rst_lsu_ready", 32'(bus.o_lsu_ready), 1);
        chk("rst_data",      bus.o_data, 0);
        chk("rst_fault",     32'(bus.o_fault), 0);
        chk("rst_rd",        32'(bus.o_rd), 0);
        rst_n = 1;
        step();

        // ALU passthrough
        issue(0, 0, 3'b000, 32'h0000_1234, 0, 5'd5, 1);
        chk("alu_valid",     32'(bus.o_valid), 1);
        chk("alu_data",      bus.o_data, 32'h0000_1234);
        chk("alu_rd",        32'(bus.o_rd), 5);
        chk("alu_lsu_ready", 32'(bus.o_lsu_ready), 1);
        drain();
        chk("alu_idle", 32'(bus.o_valid), 0);

        // LB at ...3
        issue(1, 0, 3'b000, 32'h1000_0003, 0, 5'd7, 1);
        chk("lb_req",  32'(bus.o_mem_req), 1);
        chk("lb_addr", bus.o_mem_addr, 32'h1000_0000);
        finish_mem(2, 2, 32'h80FF_0000);
        chk("lb_data",      bus.o_data, 32'hFFFF_FF80);
        chk("lb_lsu_load",  32'(bus.o_lsu_load), 1);
        chk("lb_lsu_valid", 32'(bus.o_lsu_valid), 1);
        chk("lb_lsu_ready", 32'(bus.o_lsu_ready), 1);
        drain();

        // SH at ...2
        issue(0, 1, 3'b001, 32'h2000_0002, 32'h1234_ABCD, 5'd0, 0);
        chk("sh_we",    32'(bus.o_mem_we), 1);
        chk("sh_mask",  32'(bus.o_mem_wmask), 32'(4'b1100));
        chk("sh_wdata", bus.o_mem_wdata, 32'hABCD_ABCD);
        chk("sh_addr",  bus.o_mem_addr, 32'h2000_0000);
        finish_mem(1, 1, 32'hFFFF_FFFF);
        chk("sh_wen",  32'(bus.o_wen), 0);
        chk("sh_data", bus.o_data, 32'h2000_0002);
        drain();

        // Back-to-back: ALU -> ALU -> load without a bubble
        issue(0, 0, 3'b000, 32'h0000_0011, 0, 5'd3, 1);
        set_in(0, 0, 3'b000, 32'h0000_0022, 0, 5'd4, 1);
        bus.i_valid = 1; bus.i_wb_ready = 1;
        #1;
        chk("b2b_ready", 32'(bus.o_ready), 1);
        step();
        bus.i_valid = 0; bus.i_wb_ready = 0;
        chk("b2b_valid", 32'(bus.o_valid), 1);
        chk("b2b_data",  bus.o_data, 32'h0000_0022);
        chk("b2b_rd",    32'(bus.o_rd), 4);
        set_in(1, 0, 3'b010, 32'h0000_0030, 0, 5'd6, 1);
        bus.i_valid = 1; bus.i_wb_ready = 1;
        step();
        bus.i_valid = 0; bus.i_wb_ready = 0;
        chk("b2b_mem_req", 32'(bus.o_mem_req), 1);
        finish_mem(0, 0, 32'hCAFE_F00D);
        chk("b2b_ld_data", bus.o_data, 32'hCAFE_F00D);
        drain();

        // Timeout with no rvalid
        issue(1, 0, 3'b010, 32'h0000_0040, 0, 5'd9, 1);
        finish_mem(0, TIMEOUT + 1, 32'h1234_5678);
        chk("to_valid", 32'(bus.o_valid), 1);
        chk("to_fault", 32'(bus.o_fault), 1);
        chk("to_data",  bus.o_data, 0);
        drain();
        chk("to_fault_clr", 32'(bus.o_fault), 0);

        // rvalid on the timeout cycle wins
        issue(1, 0, 3'b010, 32'h0000_0044, 0, 5'd10, 1);
        finish_mem(0, TIMEOUT, 32'hDEAD_BEEF);
        chk("race_fault", 32'(bus.o_fault), 0);
        chk("race_data",  bus.o_data, 32'hDEAD_BEEF);
        drain();

        // Load extraction table
        foreach (lv[i]) begin
            issue(1, 0, lv[i].f3, lv[i].addr, 0, 5'd11, 1);
            finish_mem(i % 2, i % 3, lv[i].rdata);
            chk("ld_tab_data", bus.o_data, lv[i].exp);
            drain();
        end

        // Store lane table
        foreach (sv[i]) begin
            issue(0, 1, sv[i].f3, sv[i].addr, sv[i].wd, 5'd0, 0);
            chk("st_tab_mask",  32'(bus.o_mem_wmask), 32'(sv[i].mask));
            chk("st_tab_wdata", bus.o_mem_wdata, sv[i].lanes);
            chk("st_tab_addr",  bus.o_mem_addr, sv[i].addr & 32'hFFFF_FFFC);
            finish_mem(1, 0, 0);
            drain();
        end

        // Load and store both set -> load
        issue(1, 1, 3'b010, 32'h0000_0050, 32'hFFFF_FFFF, 5'd2, 1);
        chk("ldst_we", 32'(bus.o_mem_we), 0);
        finish_mem(0, 0, 32'h1357_2468);
        chk("ldst_data", bus.o_data, 32'h1357_2468);
        chk("ldst_load", 32'(bus.o_lsu_load), 1);
        drain();

        // Reset during REQ drops the request immediately
        issue(1, 0, 3'b010, 32'h0000_0060, 0, 5'd12, 1);
        chk("rreq_req", 32'(bus.o_mem_req), 1);
        rst_n = 0;
        #1;
        chk("rreq_req_drop", 32'(bus.o_mem_req), 0);
        step();
        rst_n = 1;
        step();

        // Reset during WAIT, then a stale rvalid
        issue(1, 0, 3'b010, 32'h0000_0064, 0, 5'd13, 1);
        bus.i_mem_gnt = 1;
        step();
        bus.i_mem_gnt = 0;
        step();
        chk("rwait_busy", 32'(bus.o_lsu_ready), 0);
        rst_n = 0;
        #1;
        chk("rwait_req",       32'(bus.o_mem_req), 0);
        chk("rwait_valid",     32'(bus.o_valid), 0);
        chk("rwait_lsu_ready", 32'(bus.o_lsu_ready), 1);
        chk("rwait_ready",     32'(bus.o_ready), 1);
        step();
        step();
        rst_n = 1;
        step();
        bus.i_mem_rvalid = 1;
        bus.i_mem_rdata  = 32'h5A5A_5A5A;
        step();
        bus.i_mem_rvalid = 0;
        chk("late_rv_valid",     32'(bus.o_valid), 0);
        chk("late_rv_lsu_ready", 32'(bus.o_lsu_ready), 1);
        chk("late_rv_data",      bus.o_data, 0);
        step();
        chk("late_rv_idle", 32'(bus.o_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_hazard_stage.md
Name: lsu_hazard_stage

Overview:
- Load/store stage of the 5-stage pipeline, sitting between EXU and WBU.
- Accepts one instruction at a time from EXU over a valid/ready handshake and performs the memory access on a simple req/gnt/rvalid bus.
- Holds the completed result until WBU takes it.
- Is the producer of the LSU-side hazard signals (rd, wen, valid, ready, load flag, data) consumed by the decode-stage forward/stall unit.

Parameters:
- TIMEOUT, 255: cycles to wait for i_mem_rvalid after grant before forcing completion with a fault.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_valid  in  1  EXU presents an instruction.
- o_ready  out  1  stage can accept an instruction this cycle.
- i_rd  in  5  destination register.
- i_wen  in  1  instruction writes rd.
- i_load  in  1  load instruction.
- i_store  in  1  store instruction.
- i_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  32  memory address; also the ALU result for non-memory ops.
- i_wdata  in  32  store data (rs2).
- o_mem_req  out  1  bus request.
- i_mem_gnt  in  1  request accepted.
- o_mem_we  out  1  request is a write.
- o_mem_addr  out  32  word address, with [1:0] forced to 0.
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_wmask  out  4  byte strobes.
- i_mem_rvalid  in  1  read data or write acknowledge.
- i_mem_rdata  in  32  read data.
- o_valid  out  1  result available to WBU.
- i_wb_ready  in  1  WBU accepts the result.
- o_rd  out  5  result rd.
- o_wen  out  1  result writes rd.
- o_data  out  32  result data.
- o_fault  out  1  result completed by timeout.
- o_lsu_rd  out  5  hazard rd; equals o_rd.
- o_lsu_wen  out  1  hazard wen; equals o_wen.
- o_lsu_load  out  1  held instruction is a load.
- o_lsu_valid  out  1  forwardable result held; equals o_valid.
- o_lsu_ready  out  1  low while a memory access is in flight.
- o_lsu_data  out  32  forward data; equals o_data.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - All registered fields (rd, wen, load, data, fault) and the counter are cleared to 0.
  - o_mem_req=0, o_valid=0, o_lsu_ready=1, o_ready=1.
  - Reset mid-access drops the request immediately. A late i_mem_rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- Accept: a transfer occurs when i_valid && o_ready.
  - o_ready = (state==IDLE) || (state==DONE && i_wb_ready).
  - This gives back-to-back acceptance in the same cycle WBU drains.
  - On accept, latch rd, wen, load, store, funct3, addr[1:0], and data=i_addr.
- Transitions on accept:
  - Load or store: go to REQ.
  - Otherwise: go to DONE. Latency is 1 cycle; o_valid is asserted the next cycle.
  - If i_load and i_store are both set, the instruction is treated as a load.
- REQ:
  - o_mem_req=1.
  - Address, we, wdata and wmask are held stable until i_mem_gnt.
  - On gnt, go to WAIT and clear the counter.
- WAIT:
  - Counter increments each cycle.
  - On i_mem_rvalid, go to DONE. For a load, data=extracted rdata; a store keeps data unchanged.
  - When counter==TIMEOUT with no rvalid, go to DONE with fault=1 and data=0.
  - rvalid in the same cycle as the timeout wins: fault=0.
- DONE:
  - o_valid=1.
  - On i_wb_ready with no new accept, go to IDLE.
  - With a new accept, follow the accept transitions above.
- Store lanes:
  - B: mask = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - H: mask = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{half}}; addr[0] is ignored.
  - W: mask = 4'b1111; addr[1:0] is ignored.
- Load extraction:
  - Byte lane selected by addr[1:0]; half lane by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Unlisted funct3 values behave as W.
- Hazard view:
  - o_lsu_ready = !(state==REQ || state==WAIT).
  - o_lsu_load is the latched load flag, held through DONE.
  - Downstream stalls on a load only while o_lsu_ready=0 and forwards once o_lsu_valid=1.
- o_fault is held with the result and cleared when the result leaves DONE.

Test Plan:
- ALU passthrough: accept rd=5, wen=1, i_addr=0x1234, no load or store -> next cycle o_valid=1, o_data=0x1234, o_lsu_ready=1; i_wb_ready -> IDLE.
- Load LB at addr 0x...3, rdata 0x80FF_0000, gnt after 2 cycles, rvalid after 3 -> o_lsu_ready=0 for the whole REQ/WAIT window; then o_data=0xFFFF_FF80, o_lsu_load=1, o_lsu_valid=1.
- Store SH at addr 0x...2, wdata 0xABCD -> o_mem_we=1, o_mem_wmask=4'b1100, o_mem_wdata=0xABCD_ABCD, o_mem_addr[1:0]=0; completion gives o_wen=0.
- Back-to-back: DONE with i_wb_ready=1 and i_valid=1 on an ALU op -> o_ready=1 that cycle; the next result appears the following cycle with no bubble.
- Timeout: grant but no rvalid for TIMEOUT cycles -> DONE with o_fault=1, o_data=0; rvalid in the same cycle as the timeout -> o_fault=0 with the real data.
- Async reset asserted in WAIT -> o_mem_req=0, o_valid=0, o_lsu_ready=1 immediately; an rvalid pulse after reset release is ignored and the stage stays IDLE.
